// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its IF/ID message.
// The decode stage unpacks IF_ID_message with the same field offsets.
package ifu_fetch_pkg;

    localparam int IF_WIDTH       = 32;
    localparam int IF_ID_WIDTH    = 2 * IF_WIDTH;
    localparam int IF_ID_PC_LSB   = 32;
    localparam int IF_ID_INST_LSB = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if_id_reg.sv
// One-entry IF/ID output buffer holding {pc, inst} for decode.
// Flush and clear both empty it; flush wins over a load in the same cycle.
module if_id_reg
    import ifu_fetch_pkg::*;
#(
    parameter int WIDTH = IF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic               i_flush,
    input  logic [WIDTH-1:0]   i_pc,
    input  logic [WIDTH-1:0]   i_inst,
    output logic               o_valid,
    output logic [2*WIDTH-1:0] o_data
);

    logic               r_valid;
    logic [2*WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush || i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= {i_pc, i_inst};
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, redirect
// handling with stale-response dropping, and the IF/ID buffer for decode.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int               WIDTH    = IF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [WIDTH-1:0]   imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [WIDTH-1:0]   imem_resp_data,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_pc,
    input  logic               id_ready,
    output logic               if_id_valid,
    output logic [2*WIDTH-1:0] IF_ID_message
);

    fetch_state_e     r_state;
    fetch_state_e     w_stateNext;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pcNext;
    logic             r_drop;
    logic             w_dropNext;
    logic             w_handshake;
    logic             w_load;
    logic             w_consume;
    logic             r_staleOk;

    assign imem_req_valid = (r_state == S_REQ) && !rst;
    assign imem_req_addr  = r_pc;
    assign w_handshake    = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
            r_drop  <= w_dropNext;
        end
    end

    // Redirect overrides every other event; a request already accepted is marked for dropping.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_dropNext  = r_drop;
        w_load      = 1'b0;
        w_consume   = 1'b0;
        if (redirect_valid) begin
            w_pcNext = redirect_pc;
            case (r_state)
                S_REQ: begin
                    if (w_handshake) begin
                        w_stateNext = S_WAIT;
                        w_dropNext  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        w_stateNext = S_REQ;
                        w_dropNext  = 1'b0;
                    end else begin
                        w_dropNext  = 1'b1;
                    end
                end
                default: w_stateNext = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_handshake) w_stateNext = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (r_drop) begin
                            w_dropNext  = 1'b0;
                            w_stateNext = S_REQ;
                        end else begin
                            w_load      = 1'b1;
                            w_stateNext = S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (id_ready) begin
                        w_consume   = 1'b1;
                        w_pcNext    = r_pc + WIDTH'(4);
                        w_stateNext = S_REQ;
                    end
                end
                default: w_stateNext = S_REQ;
            endcase
        end
    end

    if_id_reg #(
        .WIDTH (WIDTH)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_clear (w_consume),
        .i_flush (redirect_valid),
        .i_pc    (r_pc),
        .i_inst  (imem_resp_data),
        .o_valid (if_id_valid),
        .o_data  (IF_ID_message)
    );

    // A reset that cuts off a WAIT leaves one late response legitimately landing outside WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_staleOk <= r_staleOk || (r_state == S_WAIT);
        end else if (w_handshake || imem_resp_valid) begin
            r_staleOk <= 1'b0;
        end
    end

    a_respOnlyInWait: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> ((r_state == S_WAIT) || r_staleOk));

endmodule
